// File: rtl/wdt_apb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wdt_apb_sequencer
// Brief    : APB3 master running the watchdog boot-configuration and kick
//            (unlock / clear / relock) register sequences.
// Revision : 1.0 - initial release
// ============================================================================
module wdt_apb_sequencer #(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] UNLOCK_KEY = 32'h1ACC_E551,
    parameter logic [31:0] LOCK_VAL   = 32'h0000_0000
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cfg_start,
    input  logic [31:0] cfg_load,
    input  logic [2:0]  cfg_ctl,
    input  logic        kick_req,
    input  logic        auto_kick_en,
    input  logic        irq_in,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_SETUP  = 3'd1;
    localparam logic [2:0]  S_ACCESS = 3'd2;
    localparam logic [2:0]  S_DONE   = 3'd3;

    localparam logic [11:0] c_addr_load   = 12'h000;
    localparam logic [11:0] c_addr_ctl    = 12'h008;
    localparam logic [11:0] c_addr_intclr = 12'h00C;
    localparam logic [11:0] c_addr_lock   = 12'hC00;

    localparam logic [2:0]  c_cfg_last  = 3'd4;
    localparam logic [2:0]  c_kick_last = 3'd2;
    localparam logic [7:0]  c_tmo_last  = 8'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  r_step;
    logic        r_is_cfg;
    logic [31:0] r_load;
    logic [2:0]  r_ctl;
    logic        r_pend;
    logic        r_irq_d;
    logic [7:0]  r_tmo_cnt;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [11:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_busy;
    logic        r_done;
    logic        r_cfg_err;

    logic        w_kick;
    logic [2:0]  w_nxt_idx;
    logic [11:0] w_nxt_addr;
    logic [31:0] w_nxt_data;
    logic        w_nxt_write;
    logic        w_last;
    logic        w_rd_mismatch;
    logic        w_unused;

    // Auto kicks fire only on the rising edge of irq_in, so a held level is one request.
    assign w_kick = kick_req | (auto_kick_en & irq_in & ~r_irq_d);

    assign w_nxt_idx     = (r_state == S_IDLE) ? 3'd0 : r_step + 3'd1;
    assign w_last        = r_is_cfg ? (r_step == c_cfg_last) : (r_step == c_kick_last);
    assign w_rd_mismatch = r_is_cfg & ~r_pwrite & (prdata[2:0] != r_ctl);
    assign w_unused      = ^prdata[31:3];

    // Step table; step 0 is the unlock for both sequences so it needs no latched data.
    always_comb begin
        w_nxt_addr  = c_addr_lock;
        w_nxt_data  = UNLOCK_KEY;
        w_nxt_write = 1'b1;
        if (w_nxt_idx != 3'd0) begin
            if (r_is_cfg) begin
                case (w_nxt_idx)
                    3'd1: begin
                        w_nxt_addr = c_addr_load;
                        w_nxt_data = r_load;
                    end
                    3'd2: begin
                        w_nxt_addr = c_addr_ctl;
                        w_nxt_data = {29'b0, r_ctl};
                    end
                    3'd3: begin
                        w_nxt_addr = c_addr_lock;
                        w_nxt_data = LOCK_VAL;
                    end
                    default: begin
                        w_nxt_addr  = c_addr_ctl;
                        w_nxt_data  = 32'h0;
                        w_nxt_write = 1'b0;
                    end
                endcase
            end else begin
                case (w_nxt_idx)
                    3'd1: begin
                        w_nxt_addr = c_addr_intclr;
                        w_nxt_data = 32'h1;
                    end
                    default: begin
                        w_nxt_addr = c_addr_lock;
                        w_nxt_data = LOCK_VAL;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_step    <= 3'd0;
            r_is_cfg  <= 1'b0;
            r_load    <= 32'h0;
            r_ctl     <= 3'd0;
            r_pend    <= 1'b0;
            r_irq_d   <= 1'b0;
            r_tmo_cnt <= 8'd0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 12'h0;
            r_pwdata  <= 32'h0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_irq_d <= irq_in;
            r_done  <= 1'b0;
            if (w_kick) begin
                r_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_start || w_kick || r_pend) begin
                        r_state   <= S_SETUP;
                        r_step    <= 3'd0;
                        r_busy    <= 1'b1;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_paddr   <= w_nxt_addr;
                        r_pwdata  <= w_nxt_data;
                        r_pwrite  <= w_nxt_write;
                        r_is_cfg  <= cfg_start;
                        // A simultaneous kick stays pending behind the config run.
                        if (cfg_start) begin
                            r_load    <= cfg_load;
                            r_ctl     <= cfg_ctl;
                            r_cfg_err <= 1'b0;
                        end else begin
                            r_pend <= 1'b0;
                        end
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                    r_tmo_cnt <= 8'd0;
                end
                S_ACCESS: begin
                    if (pready) begin
                        if (w_rd_mismatch) begin
                            r_cfg_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                            r_pwrite  <= 1'b0;
                            r_paddr   <= 12'h0;
                            r_pwdata  <= 32'h0;
                        end else begin
                            r_state   <= S_SETUP;
                            r_step    <= r_step + 3'd1;
                            r_penable <= 1'b0;
                            r_paddr   <= w_nxt_addr;
                            r_pwdata  <= w_nxt_data;
                            r_pwrite  <= w_nxt_write;
                        end
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        // Abort: remaining steps are dropped but done still pulses.
                        r_cfg_err <= 1'b1;
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= 12'h0;
                        r_pwdata  <= 32'h0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = {20'h0, r_paddr};
    assign pwdata  = r_pwdata;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_wdt_apb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wdt_apb_sequencer
// Brief    : Directed self-checking bench with an APB transfer scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdt_apb_sequencer;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
    } xfer_t;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_load = 32'h0;
    logic [2:0]  cfg_ctl = 3'd0;
    logic        kick_req = 1'b0;
    logic        auto_kick_en = 1'b0;
    logic        irq_in = 1'b0;
    logic        psel, penable, pwrite, pready, busy, done, cfg_err;
    logic [31:0] paddr, pwdata, prdata;

    logic [2:0]  rd_val = 3'd0;
    logic        stall_arm = 1'b0;
    logic [31:0] stall_addr = 32'h0;
    int          stall_n = 0;
    int          stall_cnt = 0;

    int          n_vec = 0;
    int          n_err = 0;
    int          acc_cycles = 0;
    logic [31:0] setup_addr = 32'h0;
    logic [31:0] setup_data = 32'h0;
    logic        setup_write = 1'b0;
    xfer_t       exp_q[$];

    wdt_apb_sequencer dut (
        .pclk         (pclk),
        .preset       (preset),
        .cfg_start    (cfg_start),
        .cfg_load     (cfg_load),
        .cfg_ctl      (cfg_ctl),
        .kick_req     (kick_req),
        .auto_kick_en (auto_kick_en),
        .irq_in       (irq_in),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 pclk = ~pclk;

    // Slave model: junk in the upper read bits, optional wait states on one address.
    assign prdata = {29'h0BAD_F00D, rd_val};
    assign pready = !(stall_arm && psel && penable && (paddr == stall_addr) && (stall_cnt < stall_n));

    always @(posedge pclk) begin
        if (psel && penable && !pready) stall_cnt <= stall_cnt + 1;
        else if (!penable) stall_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.write = w; x.data = d;
        return x;
    endfunction

    task automatic push_cfg(input logic [31:0] load, input logic [2:0] ctl);
        exp_q.push_back(mk(32'hC00, 1'b1, 32'h1ACC_E551));
        exp_q.push_back(mk(32'h000, 1'b1, load));
        exp_q.push_back(mk(32'h008, 1'b1, {29'h0, ctl}));
        exp_q.push_back(mk(32'hC00, 1'b1, 32'h0));
        exp_q.push_back(mk(32'h008, 1'b0, 32'h0));
    endtask

    task automatic push_kick();
        exp_q.push_back(mk(32'hC00, 1'b1, 32'h1ACC_E551));
        exp_q.push_back(mk(32'h00C, 1'b1, 32'h1));
        exp_q.push_back(mk(32'hC00, 1'b1, 32'h0));
    endtask

    // Bus monitor: protocol stability plus in-order scoreboard pop on each completion.
    always @(negedge pclk) begin
        xfer_t e;
        if (!preset) begin
            if (psel && !penable) begin
                setup_addr  = paddr;
                setup_data  = pwdata;
                setup_write = pwrite;
            end else if (psel && penable) begin
                acc_cycles++;
                check("acc_paddr_stable", paddr, setup_addr);
                check("acc_pwdata_stable", pwdata, setup_data);
                check("acc_pwrite_stable", {31'h0, pwrite}, {31'h0, setup_write});
                if (pready) begin
                    check("unexpected_xfer", exp_q.size(), exp_q.size() == 0 ? 32'h1 : exp_q.size());
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("xfer_addr", paddr, e.addr);
                        check("xfer_write", {31'h0, pwrite}, {31'h0, e.write});
                        check("xfer_wdata", pwdata, e.data);
                    end
                end
            end else begin
                check("idle_bus", paddr | pwdata | {30'h0, pwrite, penable}, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic start_cfg(input logic [31:0] load, input logic [2:0] ctl);
        cfg_load  = load;
        cfg_ctl   = ctl;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic start_kick();
        kick_req = 1'b1;
        tick();
        kick_req = 1'b0;
    endtask

    // Returns the cycle index (cycle 1 follows the accepting edge) on which done is high.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc <= 2000) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int cyc;
        int a0;
        int dones;
        int seen;

        // Reset values
        preset = 1'b1;
        repeat (3) tick();
        check("rst_psel", {31'h0, psel}, 32'h0);
        check("rst_penable", {31'h0, penable}, 32'h0);
        check("rst_pwrite", {31'h0, pwrite}, 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_cfg_err", {31'h0, cfg_err}, 32'h0);
        preset = 1'b0;
        tick();

        // Nominal configuration; inputs change right after accept
        rd_val = 3'b011;
        push_cfg(32'h0000_1000, 3'b011);
        a0 = acc_cycles;
        start_cfg(32'h0000_1000, 3'b011);
        cfg_load = 32'hFFFF_FFFF;
        cfg_ctl  = 3'b111;
        check("t1_busy_c1", {31'h0, busy}, 32'h1);
        check("t1_psel_c1", {31'h0, psel}, 32'h1);
        check("t1_penable_c1", {31'h0, penable}, 32'h0);
        wait_done(cyc);
        check("t1_done_cycle", cyc, 11);
        check("t1_busy_done", {31'h0, busy}, 32'h1);
        check("t1_cfg_err", {31'h0, cfg_err}, 32'h0);
        check("t1_access_cycles", acc_cycles - a0, 5);
        tick();
        check("t1_done_pulse", {31'h0, done}, 32'h0);
        check("t1_busy_idle", {31'h0, busy}, 32'h0);
        check("t1_queue", exp_q.size(), 0);

        // Readback mismatch, sticky across a kick, cleared by next config
        rd_val = 3'b001;
        push_cfg(32'h2222_0000, 3'b011);
        start_cfg(32'h2222_0000, 3'b011);
        wait_done(cyc);
        check("t2_done_cycle", cyc, 11);
        check("t2_cfg_err_set", {31'h0, cfg_err}, 32'h1);
        tick();
        push_kick();
        start_kick();
        wait_done(cyc);
        check("t2_kick_done_cycle", cyc, 7);
        check("t2_cfg_err_kick", {31'h0, cfg_err}, 32'h1);
        tick();
        rd_val = 3'b110;
        push_cfg(32'h0000_0ABC, 3'b110);
        start_cfg(32'h0000_0ABC, 3'b110);
        check("t2_cfg_err_clear", {31'h0, cfg_err}, 32'h0);
        wait_done(cyc);
        check("t2_done_cycle2", cyc, 11);
        check("t2_cfg_err_ok", {31'h0, cfg_err}, 32'h0);
        tick();

        // Three wait states on the LOAD write
        stall_addr = 32'h000;
        stall_n    = 3;
        stall_arm  = 1'b1;
        rd_val     = 3'b010;
        push_cfg(32'h1234_5678, 3'b010);
        a0 = acc_cycles;
        start_cfg(32'h1234_5678, 3'b010);
        wait_done(cyc);
        check("t3_done_cycle", cyc, 14);
        check("t3_access_cycles", acc_cycles - a0, 8);
        check("t3_cfg_err", {31'h0, cfg_err}, 32'h0);
        stall_arm = 1'b0;
        tick();

        // Timeout on the LOAD write
        stall_n   = 1000;
        stall_arm = 1'b1;
        exp_q.push_back(mk(32'hC00, 1'b1, 32'h1ACC_E551));
        a0 = acc_cycles;
        start_cfg(32'h5555_AAAA, 3'b001);
        wait_done(cyc);
        check("t4_done_cycle", cyc, 259);
        check("t4_cfg_err", {31'h0, cfg_err}, 32'h1);
        check("t4_psel_drop", {31'h0, psel}, 32'h0);
        check("t4_access_cycles", acc_cycles - a0, 256);
        repeat (5) tick();
        check("t4_psel_after", {31'h0, psel}, 32'h0);
        check("t4_busy_after", {31'h0, busy}, 32'h0);
        check("t4_queue", exp_q.size(), 0);
        stall_arm = 1'b0;

        // Kick coalescing during a config run, then one auto kick
        rd_val = 3'b101;
        push_cfg(32'hA5A5_0F0F, 3'b101);
        push_kick();
        push_kick();
        auto_kick_en = 1'b1;
        dones = 0;
        start_cfg(32'hA5A5_0F0F, 3'b101);
        check("t5_cfg_err_clear", {31'h0, cfg_err}, 32'h0);
        for (int c = 1; c <= 60; c++) begin
            kick_req  = (c == 2 || c == 4 || c == 6);
            cfg_start = (c == 5);
            cfg_load  = (c == 5) ? 32'hDEAD_BEEF : 32'hA5A5_0F0F;
            irq_in    = (c >= 14 && c < 34);
            if (done === 1'b1) dones++;
            tick();
        end
        kick_req     = 1'b0;
        cfg_start    = 1'b0;
        irq_in       = 1'b0;
        auto_kick_en = 1'b0;
        check("t5_done_count", dones, 3);
        check("t5_busy_end", {31'h0, busy}, 32'h0);
        check("t5_queue", exp_q.size(), 0);
        check("t5_cfg_err", {31'h0, cfg_err}, 32'h0);

        // Reset during ACCESS of a stalled kick with another kick pending
        stall_addr = 32'hC00;
        stall_n    = 1000;
        stall_arm  = 1'b1;
        start_kick();
        tick();
        kick_req = 1'b1;
        tick();
        kick_req = 1'b0;
        tick();
        tick();
        check("t6_mid_access", {30'h0, psel, penable}, 32'h3);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        check("t6_psel", {31'h0, psel}, 32'h0);
        check("t6_penable", {31'h0, penable}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_done", {31'h0, done}, 32'h0);
        stall_arm = 1'b0;
        seen = 0;
        repeat (10) begin
            if (psel || busy || done) seen++;
            tick();
        end
        check("t6_pending_cleared", seen, 0);
        push_kick();
        start_kick();
        wait_done(cyc);
        check("t6_kick_done_cycle", cyc, 7);
        tick();
        check("t6_busy_end", {31'h0, busy}, 32'h0);
        check("t6_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
